product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
- Downstream consumer of the 4x4 pipeline_multiplier product stream.
- Sums COUNT consecutive 8-bit products into a saturating ACC_W-bit total, then presents the total on a valid/ready output port.
- Upstream alignment: a 3-stage valid delay sits beside pipeline_multiplier at the integration level, matching its 3-cycle latency, and drives in_valid.
- Typical use: dot-product / MAC-style reduction of multiplier results.

Parameters:
- DATA_W, 8: product width; matches multiplier Y.
- COUNT, 16: products per result; legal range 1 to 255.
- ACC_W, 12: accumulator and result width; must be >= DATA_W.
- CNT_W, derived as clog2(COUNT+1): beat counter width; localparam, not user-set.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- EN  in  1  global enable; low freezes all state.
- clear  in  1  synchronous abort of the current accumulation or pending result.
- in_data  in  DATA_W  product from the multiplier (Y).
- in_valid  in  1  in_data is a valid product.
- in_ready  out  1  block can accept a product this cycle.
- out_sum  out  ACC_W  accumulated total.
- out_sat  out  1  total clipped at maximum.
- out_valid  out  1  out_sum/out_sat valid.
- out_ready  in  1  consumer accepts the result.

Behaviour:
- Reset, sampled at posedge with reset==0: applies regardless of EN and clear.
  - state=ACCUM, acc=0, cnt=0, sat_sticky=0.
  - out_sum=0, out_sat=0, out_valid=0. in_ready=1 if EN else 0.
- EN==0: no register changes (except reset). in_ready=0. No in or out transfer occurs. out_valid and out_sum hold.
- in_ready = EN && state==ACCUM, combinational.
- Beat = in_valid && in_ready. Output transfer = out_valid && out_ready && EN.
- ACCUM state, on a beat:
  - sum = acc + zero-extended in_data, computed at ACC_W+1 bits.
  - If sum > 2^ACC_W-1, clip to 2^ACC_W-1 and set sat_sticky.
  - cnt increments.
- Final beat (cnt==COUNT-1 on a beat), registered at the same edge:
  - out_sum = clipped sum including this beat; out_sat = sat_sticky OR this beat's overflow; out_valid=1.
  - acc, cnt and sat_sticky clear; state goes to HOLD.
- Latency: out_valid rises on the first edge after the final beat.
- HOLD state: in_ready=0. out_sum and out_sat are stable while out_valid=1. On transfer: out_valid=0, state goes to ACCUM.
  - One bubble: the earliest next beat is the cycle after the transfer.
- COUNT==1: every beat goes straight to HOLD with out_sum=in_data.
- clear==1 with EN==1 (reset excepted):
  - acc=0, cnt=0, sat_sticky=0, out_valid=0, out_sat=0, state goes to ACCUM.
  - out_sum holds its last value.
  - A beat in the same cycle is dropped (clear wins), and in_ready still reads 1 that cycle if in ACCUM.
  - A pending HOLD result is discarded.
- Saturation never wraps. Once set, acc stays at max for the rest of that group.
- in_data is ignored when no beat occurs; X on in_data is permitted then.

Decomposition:
- Shared package/header:
  - State encodings: ST_ACCUM=1'b0, ST_HOLD=1'b1.
  - Default DATA_W=8, shared with pipeline_multiplier.
  - MAX_ACC(ACC_W) constant function.
- One sub-module, sat_adder: combinational, parameters DATA_W and ACC_W, inputs a and b, outputs sum and ovf. Unit-tested separately.
- FSM, counter and output registers stay in product_accumulator.

Test Plan:
- Reset then 16 beats of in_data=225, out_ready=1 -> out_valid one cycle after the 16th beat, out_sum=3600, out_sat=0, in_ready=0 during the HOLD cycle.
- COUNT=32, ACC_W=12, 32 beats of 225 -> out_sum=4095, out_sat=1; the next group of 32x1 gives out_sum=32, out_sat=0.
- Result pending, out_ready=0 for 5 cycles with in_valid=1 -> out_sum and out_valid stable, in_ready=0, no beats counted; out_ready=1 -> out_valid drops the next edge, and the first new beat is accepted the following cycle.
- 7 beats of 10, then clear concurrent with an in_valid beat of 99, then 16 beats of 1 -> out_sum=16 (70 and 99 discarded).
- EN=0 for 3 cycles mid-group with in_valid=1, in_data=50 -> cnt and acc unchanged, in_ready=0; resuming 16 beats of 3 gives out_sum=48.
- Chain pipeline_multiplier -> 3-cycle valid delay -> block, A=0..15, B=15 -> out_sum=1800. Separately, reset=0 asserted mid-group and again in HOLD -> next edge all outputs 0, in_ready=1.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator: state encoding, the default
// product width (common with pipeline_multiplier) and the saturation ceiling.
package product_accumulator_pkg;

  // Width of the multiplier product Y that feeds this block.
  localparam int DATA_W_DEFAULT = 8;

  // ACCUM collects beats; HOLD presents a finished total until it is taken.
  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Largest value representable in an acc_w-bit unsigned accumulator.
  function automatic logic [63:0] MAX_ACC(input int unsigned acc_w);
    return (64'd1 << acc_w) - 64'd1;
  endfunction

endpackage

// File: rtl/product_accumulator_sat.sv
// Saturating adder: a + zero-extended b, clipped to the accumulator maximum.
// The carry out of the (ACC_W+1)-bit sum is exactly the overflow condition.
module sat_adder
  import product_accumulator_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ACC_W  = 12
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  localparam logic [ACC_W-1:0] MAX_VAL = ACC_W'(MAX_ACC(ACC_W));

  logic [ACC_W:0] wide;

  // Widen by one bit so the carry is visible, then clip on overflow.
  always_comb begin
    wide = {1'b0, a} + (ACC_W + 1)'(b);
    ovf  = wide[ACC_W];
    sum  = ovf ? MAX_VAL : wide[ACC_W-1:0];
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums COUNT consecutive products into a saturating total and hands the total
// downstream over a valid/ready port. One result is buffered; while it waits
// the input side is stalled, so the next group starts the cycle after the
// result has been taken.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int COUNT  = 16,
  parameter int ACC_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              EN,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_sat,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               sat_sticky_reg, sat_sticky_next;
  logic [ACC_W-1:0]   out_sum_reg, out_sum_next;
  logic               out_sat_reg, out_sat_next;
  logic               out_valid_reg, out_valid_next;

  logic [ACC_W-1:0]   add_sum;
  logic               add_ovf;
  logic               beat;
  logic               xfer;

  sat_adder #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_sat_adder (
    .a   (acc_reg),
    .b   (in_data),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  assign in_ready  = EN && (state_reg == ST_ACCUM);
  assign beat      = in_valid && in_ready;
  assign xfer      = out_valid_reg && out_ready && EN;
  assign out_sum   = out_sum_reg;
  assign out_sat   = out_sat_reg;
  assign out_valid = out_valid_reg;

  // Next-state logic: EN low freezes everything, clear beats any beat or
  // pending result, otherwise accumulate in ACCUM and wait for the take in HOLD.
  always_comb begin
    state_next      = state_reg;
    acc_next        = acc_reg;
    cnt_next        = cnt_reg;
    sat_sticky_next = sat_sticky_reg;
    out_sum_next    = out_sum_reg;
    out_sat_next    = out_sat_reg;
    out_valid_next  = out_valid_reg;
    if (EN) begin
      if (clear) begin
        // out_sum deliberately keeps its last value.
        state_next      = ST_ACCUM;
        acc_next        = '0;
        cnt_next        = '0;
        sat_sticky_next = 1'b0;
        out_sat_next    = 1'b0;
        out_valid_next  = 1'b0;
      end else begin
        case (state_reg)
          ST_ACCUM: begin
            if (beat) begin
              if (cnt_reg == LAST_CNT) begin
                out_sum_next    = add_sum;
                out_sat_next    = sat_sticky_reg | add_ovf;
                out_valid_next  = 1'b1;
                acc_next        = '0;
                cnt_next        = '0;
                sat_sticky_next = 1'b0;
                state_next      = ST_HOLD;
              end else begin
                acc_next        = add_sum;
                cnt_next        = cnt_reg + CNT_W'(1);
                sat_sticky_next = sat_sticky_reg | add_ovf;
              end
            end
          end
          ST_HOLD: begin
            if (xfer) begin
              out_valid_next = 1'b0;
              state_next     = ST_ACCUM;
            end
          end
          default: state_next = ST_ACCUM;
        endcase
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= ST_ACCUM;
      acc_reg        <= '0;
      cnt_reg        <= '0;
      sat_sticky_reg <= 1'b0;
      out_sum_reg    <= '0;
      out_sat_reg    <= 1'b0;
      out_valid_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      acc_reg        <= acc_next;
      cnt_reg        <= cnt_next;
      sat_sticky_reg <= sat_sticky_next;
      out_sum_reg    <= out_sum_next;
      out_sat_reg    <= out_sat_next;
      out_valid_reg  <= out_valid_next;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator. Two instances share the stimulus: dut_a with
// COUNT=16 and dut_b with COUNT=32; sel steers in_valid to one of them and
// picks which outputs are observed. Expected totals are pushed to a queue
// when a group's final beat is driven and popped when a transfer is seen.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        sel = 1'b0;
  logic [7:0]  in_data = 8'd0;

  logic        a_in_valid, b_in_valid, a_in_ready, b_in_ready;
  logic        a_out_sat, b_out_sat, a_out_valid, b_out_valid;
  logic [11:0] a_out_sum, b_out_sum;
  logic        m_in_ready, m_out_valid, m_out_sat;
  logic [11:0] m_out_sum;

  int total = 0;
  int bad = 0;
  int exp_q[$];
  int exp_acc = 0;
  int exp_cnt = 0;
  bit exp_sat = 1'b0;
  int mon_e;

  always #5 clk = ~clk;

  assign a_in_valid  = in_valid & ~sel;
  assign b_in_valid  = in_valid & sel;
  assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign m_out_valid = sel ? b_out_valid : a_out_valid;
  assign m_out_sat   = sel ? b_out_sat   : a_out_sat;
  assign m_out_sum   = sel ? b_out_sum   : a_out_sum;

  product_accumulator #(.DATA_W(8), .COUNT(16), .ACC_W(12)) dut_a (
    .clk(clk), .reset(rst_n), .EN(en), .clear(clr),
    .in_data(in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_sum(a_out_sum), .out_sat(a_out_sat), .out_valid(a_out_valid),
    .out_ready(out_ready)
  );

  product_accumulator #(.DATA_W(8), .COUNT(32), .ACC_W(12)) dut_b (
    .clk(clk), .reset(rst_n), .EN(en), .clear(clr),
    .in_data(in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_sum(b_out_sum), .out_sat(b_out_sat), .out_valid(b_out_valid),
    .out_ready(out_ready)
  );

  // Scoreboard side: a transfer happens at the coming edge, compare it now.
  always @(negedge clk) begin
    if (rst_n && en && m_out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL result_unexpected: got sum=%0d sat=%0d, required no result", m_out_sum, m_out_sat);
      end else begin
        mon_e = exp_q.pop_front();
        if (m_out_sum !== 12'(mon_e >> 1) || m_out_sat !== mon_e[0]) begin
          bad++;
          $display("FAIL result: got sum=%0d sat=%0d, required sum=%0d sat=%0d",
                   m_out_sum, m_out_sat, mon_e >> 1, mon_e[0]);
        end else begin
          $display("result dut=%0d sum=%0d sat=%0d", sel ? 32 : 16, m_out_sum, m_out_sat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_acc = 0;
    exp_cnt = 0;
    exp_sat = 1'b0;
  endtask

  // Reference model of one accepted beat.
  task automatic model_beat(input int d);
    int lim;
    int s;
    bit o;
    lim = sel ? 32 : 16;
    s = exp_acc + d;
    o = 1'b0;
    if (s > 4095) begin
      s = 4095;
      o = 1'b1;
    end
    if (exp_cnt == lim - 1) begin
      exp_q.push_back((s << 1) | int'(exp_sat | o));
      model_clear();
    end else begin
      exp_acc = s;
      exp_cnt++;
      exp_sat = exp_sat | o;
    end
  endtask

  // Present one product and wait (bounded) until it is accepted.
  task automatic send(input int d);
    bit ok;
    in_valid = 1'b1;
    in_data  = 8'(d);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL send_timeout: in_ready=%0b, required 1 within 50 cycles", m_in_ready);
    end else begin
      model_beat(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_group(input int n, input int d);
    for (int i = 0; i < n; i++) send(d);
    in_valid = 1'b0;
  endtask

  // Let any pending result be taken, bounded.
  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (!m_out_valid) break;
      step();
    end
    total++;
    if (m_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain: out_valid=%0b, required 0", m_out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    step();
    step();
    total++;
    if (a_out_sum !== 12'd0 || a_out_sat !== 1'b0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_a: sum=%0d sat=%0b valid=%0b in_ready=%0b, required 0 0 0 1",
               a_out_sum, a_out_sat, a_out_valid, a_in_ready);
    end
    total++;
    if (b_out_sum !== 12'd0 || b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_b: sum=%0d valid=%0b in_ready=%0b, required 0 0 1", b_out_sum, b_out_valid, b_in_ready);
    end
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send_group(16, 225);
    total++;
    if (m_out_valid !== 1'b1 || m_in_ready !== 1'b0 || m_out_sum !== 12'd3600) begin
      bad++;
      $display("FAIL basic_hold: valid=%0b in_ready=%0b sum=%0d, required 1 0 3600", m_out_valid, m_in_ready, m_out_sum);
    end
    step();
    total++;
    if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_after: valid=%0b in_ready=%0b, required 0 1", m_out_valid, m_in_ready);
    end
  endtask

  task automatic test_saturation();
    sel = 1'b1;
    out_ready = 1'b1;
    send_group(32, 225);
    total++;
    if (m_out_sat !== 1'b1 || m_out_sum !== 12'd4095) begin
      bad++;
      $display("FAIL sat_flag: sat=%0b sum=%0d, required 1 4095", m_out_sat, m_out_sum);
    end
    drain();
    send_group(32, 1);
    drain();
    sel = 1'b0;
  endtask

  task automatic test_back_to_back_stall();
    out_ready = 1'b0;
    send_group(16, 2);
    in_valid = 1'b1;
    in_data  = 8'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (m_out_valid !== 1'b1 || m_out_sum !== 12'd32 || m_in_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold: valid=%0b sum=%0d in_ready=%0b, required 1 32 0", m_out_valid, m_out_sum, m_in_ready);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    total++;
    if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_release: valid=%0b in_ready=%0b, required 0 1", m_out_valid, m_in_ready);
    end
    send(7);
    send_group(15, 1);
    drain();
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    send_group(7, 10);
    in_valid = 1'b1;
    in_data  = 8'd99;
    clr = 1'b1;
    @(negedge clk);
    total++;
    if (m_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL clear_ready: in_ready=%0b, required 1", m_in_ready);
    end
    step();
    clr = 1'b0;
    in_valid = 1'b0;
    model_clear();
    total++;
    if (m_out_valid !== 1'b0 || m_out_sum !== 12'd22 || m_out_sat !== 1'b0) begin
      bad++;
      $display("FAIL clear_outputs: valid=%0b sum=%0d sat=%0b, required 0 22 0", m_out_valid, m_out_sum, m_out_sat);
    end
    send_group(16, 1);
    drain();
  endtask

  task automatic test_enable();
    out_ready = 1'b1;
    send_group(5, 3);
    en = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'd50;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (m_in_ready !== 1'b0 || m_out_sum !== 12'd16 || m_out_valid !== 1'b0) begin
        bad++;
        $display("FAIL enable_freeze: in_ready=%0b sum=%0d valid=%0b, required 0 16 0", m_in_ready, m_out_sum, m_out_valid);
      end
      step();
    end
    en = 1'b1;
    in_valid = 1'b0;
    send_group(11, 3);
    drain();
  endtask

  task automatic test_chain();
    out_ready = 1'b1;
    for (int a = 0; a < 16; a++) send(a * 15);
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send_group(5, 9);
    rst_n = 1'b0;
    step();
    total++;
    if (m_out_sum !== 12'd0 || m_out_sat !== 1'b0 || m_out_valid !== 1'b0 || m_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_group: sum=%0d sat=%0b valid=%0b in_ready=%0b, required 0 0 0 1",
               m_out_sum, m_out_sat, m_out_valid, m_in_ready);
    end
    rst_n = 1'b1;
    model_clear();
    out_ready = 1'b0;
    send_group(16, 4);
    total++;
    if (m_out_valid !== 1'b1 || m_out_sum !== 12'd64) begin
      bad++;
      $display("FAIL reset_pre_hold: valid=%0b sum=%0d, required 1 64", m_out_valid, m_out_sum);
    end
    en = 1'b0;
    rst_n = 1'b0;
    step();
    total++;
    if (m_out_sum !== 12'd0 || m_out_valid !== 1'b0 || m_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_hold: sum=%0d valid=%0b in_ready=%0b, required 0 0 0", m_out_sum, m_out_valid, m_in_ready);
    end
    rst_n = 1'b1;
    en = 1'b1;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    @(negedge clk);
    total++;
    if (m_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: in_ready=%0b, required 1", m_in_ready);
    end
    step();
    out_ready = 1'b1;
    send_group(16, 5);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back_stall();
    test_clear();
    test_enable();
    test_chain();
    test_reset_mid();
    repeat (3) step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL results_outstanding: got %0d pending, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
